// File: rtl/seg7_digit_scanner.sv
// rtl/seg7_digit_scanner.sv - two-digit scan controller feeding the seven-segment decoder
// Display values are staged in a one-deep pending slot and promoted to the shadow only at frame boundaries.
module seg7_digit_scanner #(
  parameter int REFRESH_DIV   = 1200,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [3:0] nibble,
  output logic       digit_sel,
  output logic       blank,
  output logic       frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          digit_sel_q, digit_sel_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    pending_q, pending_d;
  logic          pend_full_q, pend_full_d;

  logic wrap;
  logic boundary;
  logic xfer;

  assign wrap     = (div_cnt_q == CW'(REFRESH_DIV - 1));
  assign boundary = wrap && digit_sel_q;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    div_cnt_d   = wrap ? '0 : div_cnt_q + CW'(1);
    digit_sel_d = digit_sel_q ^ wrap;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (xfer) begin
      pending_d   = in_data;
      pend_full_d = 1'b1;
    end
    // xfer and promotion are exclusive: a full pending slot holds in_ready low.
    if (boundary && pend_full_q) begin
      shadow_d    = pending_q;
      pend_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      digit_sel_q <= 1'b0;
      shadow_q    <= 8'h00;
      pending_q   <= 8'h00;
      pend_full_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_sel_q <= digit_sel_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
    end
  end

  assign in_ready   = !pend_full_q && !rst;
  assign digit_sel  = digit_sel_q;
  assign frame_done = !rst && boundary;
  assign nibble     = rst ? 4'h0 : (digit_sel_q ? shadow_q[7:4] : shadow_q[3:0]);
  assign blank      = !rst && BLANK_LEADING && digit_sel_q && (shadow_q[7:4] == 4'h0);

endmodule

// File: tb/tb_seg7_digit_scanner.sv
// tb/tb_seg7_digit_scanner.sv - scoreboard bench for seg7_digit_scanner with REFRESH_DIV=4
// Accepted values are queued with the cycle they must appear; every cycle checks all outputs.
module tb_seg7_digit_scanner;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] nibble;
  logic       digit_sel;
  logic       blank;
  logic       frame_done;

  seg7_digit_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .nibble     (nibble),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] val;
    int         at;
  } item_t;

  item_t      sbq[$];
  logic [7:0] exp_shadow;
  int         cyc;
  int         checks;
  int         passed;
  bit         accepted;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // First cycle showing a value accepted in cycle t: one after the first boundary strictly after t.
  function automatic int appear_cycle(input int t);
    int s;
    s = t + 1;
    return s + (7 - (s % 8)) + 1;
  endfunction

  task automatic cycle();
    logic       e_sel;
    logic       e_ready;
    logic [3:0] e_nib;
    bit         was_rst;
    item_t      it;
    @(negedge clk);
    was_rst  = rst;
    accepted = 1'b0;
    if (rst) begin
      sbq.delete();
      exp_shadow = 8'h00;
      chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
      chk("rst_nibble", {4'd0, nibble}, 8'h00);
      chk("rst_blank", {7'd0, blank}, 8'h00);
      chk("rst_frame_done", {7'd0, frame_done}, 8'h00);
    end else begin
      if (sbq.size() > 0 && sbq[0].at == cyc) begin
        exp_shadow = sbq[0].val;
        void'(sbq.pop_front());
      end
      e_ready = (sbq.size() == 0);
      e_sel   = ((cyc / 4) % 2) == 1;
      e_nib   = e_sel ? exp_shadow[7:4] : exp_shadow[3:0];
      chk("in_ready", {7'd0, in_ready}, {7'd0, e_ready});
      chk("digit_sel", {7'd0, digit_sel}, {7'd0, e_sel});
      chk("frame_done", {7'd0, frame_done}, {7'd0, (cyc % 8) == 7});
      chk("nibble", {4'd0, nibble}, {4'd0, e_nib});
      chk("blank", {7'd0, blank}, {7'd0, e_sel && (exp_shadow[7:4] == 4'h0)});
      if (in_valid && e_ready) begin
        it.val   = in_data;
        it.at    = appear_cycle(cyc);
        sbq.push_back(it);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    cyc = was_rst ? 0 : cyc + 1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) cycle();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_at(input int t, input logic [7:0] v);
    run_to(t);
    in_valid = 1'b1;
    in_data  = v;
    cycle();
    idle_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  task automatic hold_until_accepted(input logic [7:0] v);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      got = accepted;
    end
    chk("hold_accepted", {7'd0, got}, 8'h01);
    idle_inputs();
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    cyc        = 0;
    exp_shadow = 8'h00;
    rst        = 1'b1;
    idle_inputs();

    // Reset and free-running scan
    do_reset();
    run_to(24);

    // Single load
    do_reset();
    send_at(2, 8'h3A);
    run_to(20);

    // Back-pressure
    do_reset();
    hold_until_accepted(8'h12);
    hold_until_accepted(8'h34);
    run_to(26);

    // Transfer exactly on the frame boundary
    do_reset();
    send_at(7, 8'h56);
    run_to(20);

    // Leading-zero blanking
    do_reset();
    send_at(0, 8'h07);
    send_at(16, 8'h70);
    run_to(33);

    // Reset mid-operation, with a value offered during reset
    do_reset();
    send_at(2, 8'h3A);
    send_at(8, 8'h99);
    run_to(13);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) cycle();
    idle_inputs();
    rst = 1'b0;
    run_to(17);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
